// File: rtl/simple_cpu_pkg.sv
// Shared opcode, func, state and instruction field definitions for simple_cpu.
// SIMPLE_CPU_LOGIC_OPS_EN adds the AND/OR/XOR R-type funcs.
package simple_cpu_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_RTYPE = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;
    localparam logic [3:0] F_AND = 4'd2;
    localparam logic [3:0] F_OR  = 4'd3;
    localparam logic [3:0] F_XOR = 4'd4;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    // Low bit of each instruction field; widths are 2/2/2/2/8/4.
    localparam int OPC_LSB  = 18;
    localparam int X1_LSB   = 16;
    localparam int X2_LSB   = 14;
    localparam int X3_LSB   = 12;
    localparam int IMM_LSB  = 4;
    localparam int FUNC_LSB = 0;

    function automatic logic func_supported(input logic [3:0] func);
        logic ok;
        ok = (func == F_ADD) || (func == F_SUB);
`ifdef SIMPLE_CPU_LOGIC_OPS_EN
        ok = ok || (func == F_AND) || (func == F_OR) || (func == F_XOR);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/simple_cpu_if.sv
// Instruction bus bundle for simple_cpu; the driver side uses master, the core side slave.
interface simple_cpu_if #(
    parameter int INSTR_WIDTH = 20
);
    logic [INSTR_WIDTH-1:0] instruction;

    modport master (output instruction);
    modport slave  (input  instruction);
endinterface

// File: rtl/simple_cpu_alu.sv
// Combinational ALU for simple_cpu R-type instructions.
// Logic funcs exist only when SIMPLE_CPU_LOGIC_OPS_EN is defined.
module simple_cpu_alu
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            func,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (func)
            F_ADD: y = a + b;
            F_SUB: y = a - b;
`ifdef SIMPLE_CPU_LOGIC_OPS_EN
            F_AND: y = a & b;
            F_OR:  y = a | b;
            F_XOR: y = a ^ b;
`endif
            default: y = a;
        endcase
    end

endmodule

// File: rtl/simple_cpu.sv
// Three-state multi-cycle CPU core executing one instruction from a port.
// SIMPLE_CPU_LOGIC_OPS_EN enables AND/OR/XOR in the ALU.
module simple_cpu
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int INSTR_WIDTH = 20
) (
    input logic                   clk,
    input logic                   rst,
    input logic [INSTR_WIDTH-1:0] instruction
);

    localparam int MEM_WORDS = 2 ** ADDR_BITS;

    state_t                 state;
    logic [INSTR_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0]  regfile  [0:3];
    logic [DATA_WIDTH-1:0]  data_mem [0:MEM_WORDS-1];
    logic [DATA_WIDTH-1:0]  op_a;
    logic [DATA_WIDTH-1:0]  op_b;

    logic [1:0]            opcode;
    logic [1:0]            x1;
    logic [1:0]            x2;
    logic [1:0]            x3;
    logic [7:0]            imm8;
    logic [3:0]            func;
    logic [DATA_WIDTH-1:0] ea_full;
    logic [ADDR_BITS-1:0]  ea;
    logic [DATA_WIDTH-1:0] alu_y;

    assign opcode = ir[OPC_LSB  +: 2];
    assign x1     = ir[X1_LSB   +: 2];
    assign x2     = ir[X2_LSB   +: 2];
    assign x3     = ir[X3_LSB   +: 2];
    assign imm8   = ir[IMM_LSB  +: 8];
    assign func   = ir[FUNC_LSB +: 4];

    // Address sum wraps at the data width, then only the low ADDR_BITS select a word.
    assign ea_full = op_a + DATA_WIDTH'(imm8);
    assign ea      = ea_full[ADDR_BITS-1:0];

    simple_cpu_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a    (op_a),
        .b    (op_b),
        .func (func),
        .y    (alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            ir    <= '0;
            op_a  <= '0;
            op_b  <= '0;
            for (int i = 0; i < 4; i++) regfile[i] <= DATA_WIDTH'(i);
            for (int i = 0; i < MEM_WORDS; i++) data_mem[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= instruction;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    op_a  <= regfile[x2];
                    op_b  <= (opcode == OP_STORE) ? regfile[x1] : regfile[x3];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_RTYPE: if (func_supported(func)) regfile[x1] <= alu_y;
                        OP_LOAD:  regfile[x1] <= data_mem[ea];
                        OP_STORE: data_mem[ea] <= op_b;
                        default:  ;
                    endcase
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_cpu.sv
// Directed scoreboard bench for simple_cpu; expected writebacks are queued per instruction
// and compared against probed register/memory state after the execute edge.
module tb_simple_cpu;
    import simple_cpu_pkg::*;

    typedef struct {
        bit         is_mem;
        int         idx;
        logic [7:0] val;
        string      tag;
    } exp_t;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    exp_t sb[$];

    simple_cpu_if #(.INSTR_WIDTH(20)) bus ();

    simple_cpu #(
        .DATA_WIDTH  (8),
        .ADDR_BITS   (5),
        .INSTR_WIDTH (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (bus.instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_reg(input int idx, input logic [7:0] val, input string tag);
        exp_t e;
        e.is_mem = 1'b0; e.idx = idx; e.val = val; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic expect_mem(input int idx, input logic [7:0] val, input string tag);
        exp_t e;
        e.is_mem = 1'b1; e.idx = idx; e.val = val; e.tag = tag;
        sb.push_back(e);
    endtask

    // Drives one instruction in FETCH, scrambles the port afterwards, and runs all three edges.
    task automatic apply_stimulus(input logic [19:0] instr);
        bus.instruction = instr;
        tick(1);
        bus.instruction = 20'hFFFFF;
        tick(2);
    endtask

    task automatic check_output();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_mem) check(e.tag, 32'(dut.data_mem[e.idx]), 32'(e.val));
            else          check(e.tag, 32'(dut.regfile[e.idx]), 32'(e.val));
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        bus.instruction = '0;
        #12;
        check("reset_state", 32'(dut.state), 32'(S_FETCH));
        check("reset_ir", 32'(dut.ir), 32'h0);
        for (int i = 0; i < 4; i++) check($sformatf("reset_reg%0d", i), 32'(dut.regfile[i]), i);
        check("reset_mem17", 32'(dut.data_mem[17]), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        expect_reg(0, 8'd4, "add_r0_1p3");
        apply_stimulus(20'b01_00_01_11_00000000_0000);
        check_output();

        expect_reg(1, 8'd7, "add_r1_4p3");
        apply_stimulus(20'b01_01_00_11_00000000_0000);
        check_output();

        expect_reg(3, 8'd2, "sub_r3_4m2");
        apply_stimulus(20'b01110010000000000001);
        check_output();

        expect_mem(17, 8'd7, "store_mem17");
        apply_stimulus(20'b11011000000011110000);
        check_output();

        expect_mem(24, 8'd4, "store_mem24");
        apply_stimulus(20'b11001100000101100000);
        check_output();

        // LOAD result must appear exactly on the third edge after its fetch.
        bus.instruction = 20'b10111000000011110000;
        tick(1);
        bus.instruction = 20'hFFFFF;
        check("load_ir_latched", 32'(dut.ir), 32'hB80F0);
        tick(1);
        check("load_r3_before_exec", 32'(dut.regfile[3]), 32'd2);
        expect_reg(3, 8'd7, "load_r3_mem17");
        tick(1);
        check_output();
        check("load_back_to_fetch", 32'(dut.state), 32'(S_FETCH));

        // Reset while an ADD sits in DECODE: nothing may be written.
        bus.instruction = 20'b01_00_01_11_00000000_0000;
        tick(1);
        check("pre_reset_decode", 32'(dut.state), 32'(S_DECODE));
        rst = 1'b1;
        #1;
        check("midreset_state", 32'(dut.state), 32'(S_FETCH));
        for (int i = 0; i < 4; i++) check($sformatf("midreset_reg%0d", i), 32'(dut.regfile[i]), i);
        check("midreset_mem17", 32'(dut.data_mem[17]), 32'h0);
        check("midreset_mem24", 32'(dut.data_mem[24]), 32'h0);
        tick(1);
        @(negedge clk);
        rst = 1'b0;
        bus.instruction = 20'b01000001000000000001;
        tick(1);
        check("post_reset_fetch_ir", 32'(dut.ir), 32'h41001);
        check("post_reset_state", 32'(dut.state), 32'(S_DECODE));
        bus.instruction = 20'hFFFFF;
        expect_reg(0, 8'hFF, "sub_wrap_0m1");
        tick(2);
        check_output();

        expect_mem(2, 8'hFF, "store_mem2");
        apply_stimulus(20'b11001000000000000000);
        check_output();

        expect_reg(2, 8'hFF, "load_ea_wrap");
        apply_stimulus(20'b10101100111111110000);
        check_output();

`ifdef SIMPLE_CPU_LOGIC_OPS_EN
        expect_reg(0, 8'h02, "xor_1x3");
`else
        expect_reg(0, 8'hFF, "func4_nop");
`endif
        apply_stimulus(20'b01000111000000000100);
        check_output();

        expect_reg(1, 8'd1, "func7_nop");
        apply_stimulus(20'b01010111000000000111);
        check_output();

        expect_reg(1, 8'd1, "opcode_nop_r1");
        expect_reg(3, 8'd3, "opcode_nop_r3");
        apply_stimulus(20'b00010111000000000000);
        check_output();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
